// File: rtl/ofm_drain_reader_if.sv
// Result stream from the OFM drain reader to the host side.
// valid/ready handshake carrying one unpacked partial sum per transfer.
interface ofm_drain_reader_if #(
  parameter int ELEM_W = 16
);
  logic [ELEM_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/ofm_drain_reader.sv
// Drains packed 64-bit OFM words from buffer port B and streams
// their four 16-bit lanes, most-significant lane first.
module ofm_drain_reader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64,
  parameter int ELEM_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  ofm_drain_reader_if.master out_if,
  output logic              busy,
  output logic              done
);

  localparam int WC_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_STREAM,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [1:0]        lane_q, lane_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [ELEM_W-1:0] elem;
  logic              last_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lane_q  <= '0;
      wcnt_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lane_q  <= lane_d;
      wcnt_q  <= wcnt_d;
      hold_q  <= hold_d;
    end
  end

  assign last_word = (rem_q == ADDR_W'(1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lane_d  = lane_q;
    wcnt_d  = wcnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = num_words;
          state_d = (num_words == '0) ? S_FIN : S_FETCH;
        end
      end
      S_FETCH: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == WC_W'(RD_LAT - 1)) begin
          hold_d  = mem_dout;
          lane_d  = '0;
          state_d = S_STREAM;
        end else begin
          wcnt_d = wcnt_q + WC_W'(1);
        end
      end
      S_STREAM: begin
        if (out_if.out_ready) begin
          if (lane_q == 2'd3) begin
            rem_d = rem_q - ADDR_W'(1);
            if (last_word) begin
              state_d = S_FIN;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_FETCH;
            end
          end else begin
            lane_d = lane_q + 2'd1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    elem = '0;
    unique case (lane_q)
      2'd0: elem = hold_q[4*ELEM_W-1 -: ELEM_W];
      2'd1: elem = hold_q[3*ELEM_W-1 -: ELEM_W];
      2'd2: elem = hold_q[2*ELEM_W-1 -: ELEM_W];
      2'd3: elem = hold_q[ELEM_W-1 -: ELEM_W];
      default: elem = '0;
    endcase
  end

  assign mem_en           = (state_q == S_FETCH);
  assign mem_addr         = mem_en ? addr_q : '0;
  assign out_if.out_valid = (state_q == S_STREAM);
  assign out_if.out_data  = out_if.out_valid ? elem : '0;
  assign out_if.out_last  = out_if.out_valid && (lane_q == 2'd3)
                            && last_word;
  assign busy = (state_q == S_FETCH) || (state_q == S_WAIT)
                || (state_q == S_STREAM);
  assign done = (state_q == S_FIN);

endmodule

// File: doc/ofm_drain_reader.md
# ofm_drain_reader

Reads a finished output feature map back out of the output buffer and streams it to the host side. On `start`, it fetches `num_words` consecutive 64-bit words from the buffer's read port, starting at `base_addr`. Each word holds four packed 16-bit partial sums, which the block unpacks and emits one per handshake, most-significant lane first. It is the read-side counterpart of the packer/writer path that fills the output buffer, and it sits between that buffer's port B and the result interface.

## Interface
Parameters:
- `ADDR_W`, 16, width of buffer address and of the word count.
- `DATA_W`, 64, buffer word width. Fixed at 4 × `ELEM_W`.
- `ELEM_W`, 16, width of one unpacked result.
- `RD_LAT`, 2, buffer read latency in cycles, from the `mem_en` cycle to valid `mem_dout`. Legal range is 1..4.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a drain. Sampled only in IDLE.
- `base_addr`  in  `ADDR_W`  first buffer word address. Latched when `start` is accepted.
- `num_words`  in  `ADDR_W`  number of words to drain. Latched when `start` is accepted.
- `mem_en`  out  1  buffer read enable (drives port B `enb`).
- `mem_addr`  out  `ADDR_W`  buffer read address (drives `addrb`).
- `mem_dout`  in  `DATA_W`  buffer read data (from `doutb`).
- `out_data`  out  `ELEM_W`  unpacked result.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  the consumer accepts `out_data`.
- `out_last`  out  1  marks the final element of the drain. Qualified by `out_valid`.
- `busy`  out  1  high from start acceptance until `done`.
- `done`  out  1  one-cycle pulse when the drain completes.

## Operation
- States:
  - IDLE
  - FETCH: one cycle. `mem_en`=1, `mem_addr`=current address.
  - WAIT: count `RD_LAT` cycles.
  - STREAM: 4 lanes.
  - FIN: one cycle. `done`=1.
- IDLE to FETCH: `start`=1 and `num_words`≠0. `base_addr` and `num_words` are latched, and `busy` rises.
- IDLE to FIN: `start`=1 and `num_words`=0. No read is issued and no element is emitted.
- WAIT to STREAM: on the edge that completes `RD_LAT` cycles after FETCH. `mem_dout` is captured into a holding register and the lane index is set to 0.
- Lane order:
  - lane 0 = bits [63:48]
  - lane 1 = bits [47:32]
  - lane 2 = bits [31:16]
  - lane 3 = bits [15:0]
- STREAM advances one lane on each edge where `out_valid` and `out_ready` are both 1.
  - After lane 3 with words remaining, the address increments (wrapping modulo 2^`ADDR_W`) and the state goes to FETCH.
  - After lane 3 of the last word, the state goes to FIN.
- FIN to IDLE unconditionally. `busy` falls in the same cycle that `done` is high.
- `start` while `busy`=1 is ignored. The latched parameters do not change.
- There is no prefetch. Each word costs a gap of `RD_LAT`+1 cycles with `out_valid`=0.

## Timing
- Reset (asynchronous, `rst_n`=0): all outputs are 0, the state is IDLE, and the counters and holding register are cleared.
- Reset mid-drain aborts immediately. No `done` is produced, and the next drain restarts cleanly.
- Start to first element: `start` is sampled at edge 0.
  - `mem_en` is high in cycle 0–1.
  - Data is captured at edge `RD_LAT`+1.
  - `out_valid` is first high after edge `RD_LAT`+1, i.e. after edge 3 at the default latency.
- `mem_en` is high for exactly one cycle per word, `num_words` times in total.
- Handshake rules:
  - While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
  - `out_valid` never drops without a transfer.
- `out_valid` does not depend combinationally on `out_ready`.
- With `out_ready` held at 1, a word streams in 4 consecutive cycles.
- `out_last`=1 only on lane 3 of the final word.
- `done` pulses in the cycle after the final transfer edge.
- `num_words`=0: `done` is high in the cycle after the start edge, and `mem_en` stays 0.
- Address wrap: with `base_addr`=0xFFFF and `num_words`=2, the reads go to 0xFFFF and then 0x0000.

## Test plan
- Basic drain:
  - Stimulus: buffer word 5 = 0x1111_2222_3333_4444, `start` with base=5, n=1, `out_ready` held 1.
  - Required: `out_data` = 0x1111, 0x2222, 0x3333, 0x4444 on 4 consecutive cycles, beginning after edge 3; `out_last` on 0x4444; one `done` pulse.
- Multi-word drain:
  - Stimulus: n=3 from base 0.
  - Required: 12 elements in address order; `mem_en` pulses exactly 3 times, at addresses 0, 1, 2; a 3-cycle valid gap between words.
- Backpressure:
  - Stimulus: `out_ready` toggled at random, including held 0 for 10 cycles on lane 2.
  - Required: no element lost or duplicated, and data stable while stalled.
- Zero-length drain:
  - Stimulus: `start` with n=0.
  - Required: `mem_en` never asserts, `out_valid` never asserts, `done` high 1 cycle after the start edge.
- Start while busy and address wrap:
  - Stimulus: second `start` during a drain; a drain with base 0xFFFF and n=2.
  - Required: the second `start` is ignored; the wrap drain reads 0xFFFF then 0x0000.
- Reset mid-stream:
  - Stimulus: `rst_n`=0 while on lane 1.
  - Required: all outputs 0 immediately and no `done`; a subsequent n=1 drain is correct.
